// File: rtl/mfm_write_encoder.sv
// rtl/mfm_write_encoder.sv - MFM write encoder producing timed active-low WRDATA pulses
//
// Purpose: takes bytes over a valid/ready handshake into a one-entry holding
// register, MFM-encodes each into 16 bitcells (clock cell first, MSB first),
// or substitutes a raw 16-cell sync pattern, and emits one active-low pulse
// per '1' cell on the floppy WRDATA line. Words are back-to-back with
// continuous cell timing while the holding register keeps up.
//
// Ports:
//   CLK_PLL32MHZ   master clock
//   RESET_N        asynchronous active-low reset
//   ENABLE         write gate; low aborts and flushes everything
//   DATA_IN        byte to encode
//   SYNC_IN        send SYNC_WORD_IN cells instead of encoding DATA_IN
//   DATA_VALID     DATA_IN/SYNC_IN valid
//   DATA_READY     holding register empty (registered)
//   SYNC_WORD_IN   raw cell pattern for sync bytes, MSB first
//   FD_WRDATA_OUT  registered active-low write pulse
//   BUSY           cell stream active on FD_WRDATA_OUT
//   UNDERRUN       sticky: holding register was empty at a word boundary
module mfm_write_encoder #(
   parameter int CLKS_PER_BITCELL = 32,
   parameter int PULSE_WIDTH      = 8
) (
   input  logic        CLK_PLL32MHZ,
   input  logic        RESET_N,
   input  logic        ENABLE,
   input  logic [7:0]  DATA_IN,
   input  logic        SYNC_IN,
   input  logic        DATA_VALID,
   output logic        DATA_READY,
   input  logic [15:0] SYNC_WORD_IN,
   output logic        FD_WRDATA_OUT,
   output logic        BUSY,
   output logic        UNDERRUN
);

   localparam int CW = (CLKS_PER_BITCELL > 1) ? $clog2(CLKS_PER_BITCELL) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BITCELL - 1);
   localparam logic [CW-1:0] PW_CNT   = CW'(PULSE_WIDTH);

   typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

   state_t          r_state,     w_state_nxt;
   logic            r_hold_full, w_hold_full_nxt;
   logic            r_hold_sync, w_hold_sync_nxt;
   logic [7:0]      r_hold_data, w_hold_data_nxt;
   logic            r_ready,     w_ready_nxt;
   logic [15:0]     r_shift,     w_shift_nxt;
   logic [CW-1:0]   r_cnt,       w_cnt_nxt;
   logic [3:0]      r_idx,       w_idx_nxt;
   logic            r_prev,      w_prev_nxt;
   logic            r_wrdata,    w_wrdata_nxt;
   logic            r_busy,      w_busy_nxt;
   logic            r_underrun,  w_underrun_nxt;

   logic            w_load;
   logic            w_capture;
   logic [15:0]     w_load_word;

   // c_i = ~prev & ~d_i, and prev follows each data bit through the byte.
   function automatic logic [15:0] f_mfm_encode(input logic [7:0] d, input logic p_in);
      logic [15:0] w;
      logic        p;
      w = '0;
      p = p_in;
      for (int i = 7; i >= 0; i--) begin
         w[2*i+1] = ~p & ~d[i];
         w[2*i]   = d[i];
         p        = d[i];
      end
      return w;
   endfunction

   assign w_load_word = r_hold_sync ? SYNC_WORD_IN : f_mfm_encode(r_hold_data, r_prev);
   assign w_capture   = DATA_VALID & r_ready;

   always_comb begin
      w_state_nxt     = r_state;
      w_hold_full_nxt = r_hold_full;
      w_hold_sync_nxt = r_hold_sync;
      w_hold_data_nxt = r_hold_data;
      w_ready_nxt     = r_ready;
      w_shift_nxt     = r_shift;
      w_cnt_nxt       = r_cnt;
      w_idx_nxt       = r_idx;
      w_prev_nxt      = r_prev;
      w_wrdata_nxt    = 1'b1;
      w_busy_nxt      = 1'b0;
      w_underrun_nxt  = r_underrun;
      w_load          = 1'b0;

      if (!ENABLE) begin
         w_state_nxt     = ST_IDLE;
         w_hold_full_nxt = 1'b0;
         w_ready_nxt     = 1'b0;
         w_cnt_nxt       = '0;
         w_idx_nxt       = 4'd15;
         w_prev_nxt      = 1'b0;
         w_underrun_nxt  = 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (r_hold_full)
                  w_load = 1'b1;
            end
            ST_SHIFT: begin
               if (r_cnt == LAST_CNT) begin
                  w_cnt_nxt = '0;
                  if (r_idx == 4'd0) begin
                     if (r_hold_full) begin
                        w_load = 1'b1;
                     end else begin
                        w_state_nxt    = ST_IDLE;
                        w_underrun_nxt = 1'b1;
                     end
                  end else begin
                     w_idx_nxt = r_idx - 4'd1;
                  end
               end else begin
                  w_cnt_nxt = r_cnt + CW'(1);
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase

         if (w_load) begin
            w_state_nxt = ST_SHIFT;
            w_shift_nxt = w_load_word;
            w_cnt_nxt   = '0;
            w_idx_nxt   = 4'd15;
            w_prev_nxt  = w_load_word[0];
         end

         // A load and a capture on the same edge leave the register full.
         w_hold_full_nxt = (r_hold_full & ~w_load) | w_capture;
         if (w_capture) begin
            w_hold_sync_nxt = SYNC_IN;
            w_hold_data_nxt = DATA_IN;
         end
         w_ready_nxt = ~w_hold_full_nxt;

         // Output stage lags the cell counters by one clock; BUSY shares that
         // lag so it brackets exactly the cells appearing on WRDATA.
         w_wrdata_nxt = ~((r_state == ST_SHIFT) && r_shift[r_idx] && (r_cnt < PW_CNT));
         w_busy_nxt   = (r_state == ST_SHIFT);
      end
   end

   always_ff @(posedge CLK_PLL32MHZ or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state     <= ST_IDLE;
         r_hold_full <= 1'b0;
         r_hold_sync <= 1'b0;
         r_hold_data <= '0;
         r_ready     <= 1'b0;
         r_shift     <= '0;
         r_cnt       <= '0;
         r_idx       <= 4'd15;
         r_prev      <= 1'b0;
         r_wrdata    <= 1'b1;
         r_busy      <= 1'b0;
         r_underrun  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_hold_full <= w_hold_full_nxt;
         r_hold_sync <= w_hold_sync_nxt;
         r_hold_data <= w_hold_data_nxt;
         r_ready     <= w_ready_nxt;
         r_shift     <= w_shift_nxt;
         r_cnt       <= w_cnt_nxt;
         r_idx       <= w_idx_nxt;
         r_prev      <= w_prev_nxt;
         r_wrdata    <= w_wrdata_nxt;
         r_busy      <= w_busy_nxt;
         r_underrun  <= w_underrun_nxt;
      end
   end

   assign DATA_READY    = r_ready;
   assign FD_WRDATA_OUT = r_wrdata;
   assign BUSY          = r_busy;
   assign UNDERRUN      = r_underrun;

endmodule

// File: tb/tb_mfm_write_encoder.sv
// tb/tb_mfm_write_encoder.sv - directed self-checking bench for mfm_write_encoder
module tb_mfm_write_encoder;

   logic        clk;
   logic        rst_n;
   logic        enable;
   logic [7:0]  data_in;
   logic        sync_in;
   logic        data_valid;
   logic        data_ready;
   logic [15:0] sync_word;
   logic        wrdata;
   logic        busy;
   logic        underrun;

   int n_tests;
   int n_fail;
   int cyc;
   int busy_rise;
   int start_c;
   logic last_wr;
   logic last_busy;
   int p_start[$];
   int p_width[$];

   mfm_write_encoder #(.CLKS_PER_BITCELL(32), .PULSE_WIDTH(8)) dut (
      .CLK_PLL32MHZ (clk),
      .RESET_N      (rst_n),
      .ENABLE       (enable),
      .DATA_IN      (data_in),
      .SYNC_IN      (sync_in),
      .DATA_VALID   (data_valid),
      .DATA_READY   (data_ready),
      .SYNC_WORD_IN (sync_word),
      .FD_WRDATA_OUT(wrdata),
      .BUSY         (busy),
      .UNDERRUN     (underrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      last_wr   = 1'b1;
      last_busy = 1'b0;
      busy_rise = -1;
      start_c   = 0;
   end

   always @(negedge clk) begin
      if (last_wr && !wrdata) begin
         p_start.push_back(cyc);
         start_c = cyc;
      end
      if (!last_wr && wrdata)
         p_width.push_back(cyc - start_c);
      if (!last_busy && busy)
         busy_rise = cyc;
      last_wr   = wrdata;
      last_busy = busy;
   end

   // Rebuild one 16-cell word from the pulses starting in [base, base+512);
   // bit 16 flags a pulse that is not aligned to a cell boundary.
   function automatic logic [16:0] decode(input int base);
      logic [16:0] r;
      int off;
      r = '0;
      foreach (p_start[k]) begin
         off = p_start[k] - base;
         if (off >= 0 && off < 512) begin
            if (off % 32 != 0) r[16] = 1'b1;
            else r[15 - off/32] = 1'b1;
         end
      end
      return r;
   endfunction

   task automatic clear_mon();
      p_start.delete();
      p_width.delete();
      busy_rise = -1;
   endtask

   task automatic rearm();
      @(negedge clk) enable = 1'b0;
      @(negedge clk) enable = 1'b1;
      @(negedge clk);
   endtask

   task automatic send(input logic [7:0] b, input logic s);
      int n;
      @(negedge clk);
      data_in    = b;
      sync_in    = s;
      data_valid = 1'b1;
      n = 0;
      while (!data_ready && n < 3000) begin
         @(negedge clk);
         n++;
      end
      n_tests++;
      if (!data_ready) begin
         n_fail++;
         $display("FAIL send_timeout: ready=%b after %0d cycles, required 1", data_ready, n);
      end
      @(posedge clk);
      #1 data_valid = 1'b0;
      sync_in = 1'b0;
   endtask

   task automatic test_reset();
      n_tests++; if (wrdata !== 1'b1)   begin n_fail++; $display("FAIL reset_wrdata: got %b want 1", wrdata); end
      n_tests++; if (data_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", data_ready); end
      n_tests++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_tests++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL reset_underrun: got %b want 0", underrun); end
      @(negedge clk) data_valid = 1'b1;
      repeat (4) @(negedge clk);
      n_tests++; if (data_ready !== 1'b0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL disabled_ignore: ready=%b busy=%b want 0 0", data_ready, busy);
      end
      data_valid = 1'b0;
   endtask

   task automatic test_zero_byte();
      logic [16:0] d;
      clear_mon();
      @(negedge clk) enable = 1'b1;
      send(8'h00, 1'b0);
      repeat (600) @(negedge clk);
      d = decode(busy_rise);
      n_tests++; if (p_start.size() != 8) begin n_fail++; $display("FAIL zero_count: got %0d want 8", p_start.size()); end
      n_tests++; if (d !== {1'b0, 16'hAAAA}) begin n_fail++; $display("FAIL zero_cells: got %h want 0aaaa", d); end
      foreach (p_width[k]) begin
         n_tests++; if (p_width[k] != 8) begin n_fail++; $display("FAIL zero_width: got %0d want 8", p_width[k]); end
      end
      n_tests++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL zero_underrun: got %b want 1", underrun); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy: got %b want 0", busy); end
   endtask

   task automatic test_ff_byte();
      logic [16:0] d;
      rearm();
      clear_mon();
      n_tests++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL ff_underrun_clear: got %b want 0", underrun); end
      send(8'hFF, 1'b0);
      repeat (600) @(negedge clk);
      d = decode(busy_rise);
      n_tests++; if (p_start.size() != 8) begin n_fail++; $display("FAIL ff_count: got %0d want 8", p_start.size()); end
      n_tests++; if (d !== {1'b0, 16'h5555}) begin n_fail++; $display("FAIL ff_cells: got %h want 05555", d); end
      n_tests++; if (p_start.size() < 1 || p_start[0] - busy_rise != 32) begin
         n_fail++; $display("FAIL ff_first_delay: got %0d want 32", p_start.size() > 0 ? p_start[0] - busy_rise : -1);
      end
   endtask

   task automatic test_back_to_back();
      logic [16:0] d0, d1;
      rearm();
      clear_mon();
      sync_word = 16'h4489;
      send(8'hA1, 1'b1);
      send(8'h4E, 1'b0);
      repeat (990) @(negedge clk);
      n_tests++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL b2b_underrun: got %b want 0", underrun); end
      repeat (150) @(negedge clk);
      d0 = decode(busy_rise);
      d1 = decode(busy_rise + 512);
      n_tests++; if (d0 !== {1'b0, 16'h4489}) begin n_fail++; $display("FAIL b2b_sync: got %h want 04489", d0); end
      n_tests++; if (d1 !== {1'b0, 16'h1254}) begin n_fail++; $display("FAIL b2b_4e: got %h want 01254", d1); end
      n_tests++; if (p_start.size() != 10 || p_start[5] - p_start[4] != 128) begin
         n_fail++; $display("FAIL b2b_gap: count=%0d gap=%0d want 10 128", p_start.size(),
                            p_start.size() > 5 ? p_start[5] - p_start[4] : -1);
      end
   endtask

   task automatic test_prev_zero();
      logic [16:0] d0, d1;
      rearm();
      clear_mon();
      send(8'h00, 1'b0);
      send(8'h4E, 1'b0);
      repeat (1100) @(negedge clk);
      d0 = decode(busy_rise);
      d1 = decode(busy_rise + 512);
      n_tests++; if (d0 !== {1'b0, 16'hAAAA}) begin n_fail++; $display("FAIL prev0_first: got %h want 0aaaa", d0); end
      n_tests++; if (d1 !== {1'b0, 16'h9254}) begin n_fail++; $display("FAIL prev0_4e: got %h want 09254", d1); end
   endtask

   task automatic test_abort();
      int n;
      logic [16:0] d;
      rearm();
      clear_mon();
      send(8'hFF, 1'b0);
      send(8'h12, 1'b0);
      n = 0;
      while (cyc != busy_rise + 163 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      n_tests++; if (wrdata !== 1'b0) begin n_fail++; $display("FAIL abort_mid_pulse: got %b want 0", wrdata); end
      enable = 1'b0;
      @(negedge clk);
      n_tests++; if (wrdata !== 1'b1 || busy !== 1'b0 || data_ready !== 1'b0) begin
         n_fail++; $display("FAIL abort_outputs: wr=%b busy=%b ready=%b want 1 0 0", wrdata, busy, data_ready);
      end
      repeat (3) @(negedge clk);
      clear_mon();
      enable = 1'b1;
      send(8'h00, 1'b0);
      repeat (600) @(negedge clk);
      d = decode(busy_rise);
      n_tests++; if (p_start.size() != 8 || d !== {1'b0, 16'hAAAA}) begin
         n_fail++; $display("FAIL abort_reenable: count=%0d cells=%h want 8 0aaaa", p_start.size(), d);
      end
   endtask

   task automatic test_stream();
      int t[5];
      int n, g;
      logic [16:0] d;
      logic [15:0] exp_w[5];
      exp_w = '{16'hAAAA, 16'hAAA9, 16'h2AA4, 16'hAAA5, 16'h2A92};
      rearm();
      clear_mon();
      n = 0;
      g = 0;
      @(negedge clk);
      data_in    = 8'h00;
      data_valid = 1'b1;
      while (n < 5 && g < 4000) begin
         if (data_ready) begin
            t[n] = cyc + 1;
            n++;
            @(posedge clk);
            #1;
            if (n == 5) data_valid = 1'b0;
            else data_in = 8'(n);
         end
         @(negedge clk);
         g++;
      end
      data_valid = 1'b0;
      n_tests++; if (n != 5) begin n_fail++; $display("FAIL stream_transfers: got %0d want 5", n); end
      for (int k = 1; k < 4; k++) begin
         n_tests++; if (t[k+1] - t[k] != 512) begin
            n_fail++; $display("FAIL stream_interval%0d: got %0d want 512", k, t[k+1] - t[k]);
         end
      end
      repeat (1200) @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         d = decode(busy_rise + 512 * k);
         n_tests++; if (d !== {1'b0, exp_w[k]}) begin
            n_fail++; $display("FAIL stream_word%0d: got %h want 0%h", k, d, exp_w[k]);
         end
      end
      n_tests++; if (p_start.size() != 36) begin n_fail++; $display("FAIL stream_count: got %0d want 36", p_start.size()); end
   endtask

   task automatic test_async_reset();
      int n;
      rearm();
      clear_mon();
      send(8'hFF, 1'b0);
      n = 0;
      while (cyc != busy_rise + 35 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      n_tests++; if (wrdata !== 1'b0) begin n_fail++; $display("FAIL areset_pre: got %b want 0", wrdata); end
      #1 rst_n = 1'b0;
      #1;
      n_tests++; if (wrdata !== 1'b1 || busy !== 1'b0 || data_ready !== 1'b0) begin
         n_fail++; $display("FAIL areset_outputs: wr=%b busy=%b ready=%b want 1 0 0", wrdata, busy, data_ready);
      end
      @(negedge clk) rst_n = 1'b1;
   endtask

   initial begin
      n_tests    = 0;
      n_fail     = 0;
      rst_n      = 1'b0;
      enable     = 1'b0;
      data_in    = 8'h00;
      sync_in    = 1'b0;
      data_valid = 1'b0;
      sync_word  = 16'h4489;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      test_reset();
      test_zero_byte();
      test_ff_byte();
      test_back_to_back();
      test_prev_zero();
      test_abort();
      test_stream();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mfm_write_encoder.md
Name: mfm_write_encoder

Overview:
- MFM write-side counterpart of the MFM sync word detector.
- Accepts a byte stream over a valid/ready handshake and MFM-encodes each byte into 16 bitcells, clock cell first, MSB first.
- Drives timed active-low write pulses to the floppy WRDATA line.
- Bytes flagged as sync are replaced verbatim by a 16-bit raw cell pattern (e.g. 0x4489 for A1 with a missing clock), the same pattern the detector matches.

Parameters:
- CLKS_PER_BITCELL, 32, master clocks per bitcell (32 MHz / 32 = 1 µs cell, 500 kbps MFM); minimum 4.
- PULSE_WIDTH, 8, master clocks WRDATA is held low per flux transition; must be < CLKS_PER_BITCELL.

Ports:
- CLK_PLL32MHZ  in  1  master clock; single clock domain.
- RESET_N  in  1  asynchronous, active-low reset.
- ENABLE  in  1  write enable (write gate); 0 aborts and flushes.
- DATA_IN  in  8  byte to encode.
- SYNC_IN  in  1  with DATA_IN: emit SYNC_WORD_IN cells instead of encoding DATA_IN.
- DATA_VALID  in  1  DATA_IN/SYNC_IN valid.
- DATA_READY  out  1  holding register empty; transfer on DATA_VALID & DATA_READY.
- SYNC_WORD_IN  in  16  raw cell pattern for sync bytes; MSB sent first.
- FD_WRDATA_OUT  out  1  registered active-low write pulse.
- BUSY  out  1  shifter active.
- UNDERRUN  out  1  sticky: stream ran dry mid-write.

Behaviour:
- Reset values: FD_WRDATA_OUT=1, DATA_READY=0, BUSY=0, UNDERRUN=0. Holding register empty. prev_data_bit=0. State IDLE.
- Holding register (one entry):
  - DATA_READY = ENABLE & holding-empty, registered.
  - Capture {SYNC_IN, DATA_IN} on a rising edge where DATA_VALID & DATA_READY.
  - DATA_READY deasserts on the following edge.
- Encoding, for a normal byte d[7:0]:
  - For each i = 7..0: cell pair {c_i, d_i}, where c_i = ~prev & ~d_i.
  - prev starts as prev_data_bit and then takes d_i.
  - For a sync byte: cells = SYNC_WORD_IN sampled at load time.
  - prev_data_bit after any word = cell[0] of that word.
- State machine:
  - IDLE: BUSY=0. If ENABLE and holding full: load the shifter, empty the holding register, go SHIFT. Load occurs one edge after capture at the earliest.
  - SHIFT: a cell counter runs 0..CLKS_PER_BITCELL-1 and a cell index runs 15..0.
    - FD_WRDATA_OUT=0 while the current cell bit is 1 and cell counter < PULSE_WIDTH; otherwise 1.
    - On the last clock of cell 0: if holding is full, load the next word with no gap (counter→0, index→15). Cell timing is therefore continuous across words.
    - If holding is empty at that point: set UNDERRUN and go IDLE.
  - Pulse for the first cell of a loaded word begins on the edge after the load.
- IDLE after reset or after an ENABLE fall resets prev_data_bit to 0.
- ENABLE falling in any state:
  - Next edge: state IDLE, FD_WRDATA_OUT=1 (truncates any pulse in progress), holding flushed, BUSY=0, DATA_READY=0, UNDERRUN cleared.
  - UNDERRUN is cleared only by ENABLE=0 or reset.
- DATA_VALID while ENABLE=0 is ignored (DATA_READY=0).
- A capture and a load on the same edge are legal: the holding register ends full with the new byte.
- Reset asserted mid-word: all outputs take reset values immediately (asynchronous).

Test Plan:
- Reset, ENABLE=1, send 0x00 then idle → cells 0xAAAA: 8 low pulses of 8 clocks, starting at cells 15,13,…,1, spaced 64 clocks. Then UNDERRUN=1 and BUSY=0.
- Send 0xFF → cells 0x5555; pulse count 8; first pulse starts 32 clocks after BUSY rises.
- SYNC_WORD_IN=0x4489: send sync, then 0x4E → cells 0x4489 then 0x1254 (prev=1 suppresses the leading clock). No gap between words: the pulse for the final cell of word 1 and the next pulse are exactly 32·k clocks apart. Feed bytes back-to-back with DATA_READY honoured; UNDERRUN stays 0.
- Send 0x4E after a word ending in data bit 0 (byte 0x00) → cells 0x9254.
- Drop ENABLE at cell 10 counter 3 of a 1-cell pulse → FD_WRDATA_OUT=1 on the next edge, BUSY=0, DATA_READY=0. Re-enable and send 0x00 → 0xAAAA with prev reset to 0.
- Hold DATA_VALID=1 continuously with an incrementing byte → exactly one byte consumed per 512 clocks; none dropped or duplicated.
